// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the two-requester AES core arbiter.
package aes_arb_pkg;

  localparam int AES_W              = 128;
  localparam int ID_W               = 1;
  localparam int TIMEOUT_CYCLES_DEF = 64;
  localparam int GAP_CYCLES_DEF     = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant: a lone valid wins, a tie goes to the requester
// that was not granted last. Grant is one-hot, or zero when not enabled.
module aes_rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      if (valid0_i && valid1_i) begin
        grant_o = last_grant_i ? 2'b01 : 2'b10;
      end else if (valid0_i) begin
        grant_o = 2'b01;
      end else if (valid1_i) begin
        grant_o = 2'b10;
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES_top core between two valid/ready requesters and returns the
// tagged result on a backpressured response channel. Macro AES_ARB_TIMEOUT_EN adds a RUN timeout.
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF
) (
  input  logic             AES_clk,
  input  logic             AES_rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [AES_W-1:0] req0_data,
  input  logic [AES_W-1:0] req0_key,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [AES_W-1:0] req1_data,
  input  logic [AES_W-1:0] req1_key,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [AES_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             core_en,
  output logic [AES_W-1:0] core_data,
  output logic [AES_W-1:0] core_key,
  input  logic [AES_W-1:0] core_out,
  input  logic             core_out_valid
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  arb_state_e       state_q;
  logic             last_grant_q;
  logic [ID_W-1:0]  id_q;
  logic             rsp_valid_q;
  logic [AES_W-1:0] rsp_data_q;
  logic             core_en_q;
  logic [AES_W-1:0] core_data_q;
  logic [AES_W-1:0] core_key_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic [1:0]       grant;

`ifdef AES_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt_q;
  logic            rsp_err_q;
`endif

  // Ready is held low while reset is asserted so no handshake can complete.
  aes_rr_arb2 u_arb (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .enable_i     ((state_q == ST_IDLE) && !AES_rst),
    .grant_o      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign core_en    = core_en_q;
  assign core_data  = core_data_q;
  assign core_key   = core_key_q;

`ifdef AES_ARB_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge AES_clk) begin
    if (AES_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      core_en_q    <= 1'b0;
      core_data_q  <= '0;
      core_key_q   <= '0;
      gap_cnt_q    <= '0;
`ifdef AES_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            core_data_q  <= grant[0] ? req0_data : req1_data;
            core_key_q   <= grant[0] ? req0_key  : req1_key;
            id_q         <= grant[1];
            last_grant_q <= grant[1];
            core_en_q    <= 1'b1;
            state_q      <= ST_RUN;
`ifdef AES_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
          end
        end
        ST_RUN: begin
          // A result arriving on the timeout cycle still counts as a normal result.
          if (core_out_valid) begin
            rsp_data_q  <= core_out;
            rsp_valid_q <= 1'b1;
            core_en_q   <= 1'b0;
            state_q     <= ST_RESP;
`ifdef AES_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (to_cnt_q == TO_LIMIT) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            core_en_q   <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            to_cnt_q    <= to_cnt_q + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            gap_cnt_q   <= GAP_LOAD;
            state_q     <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with an 11-cycle data^key core model and a response scoreboard.
module tb_aes_core_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [0:0]   rsp_id;
  logic [127:0] rsp_data;
  logic         core_en, core_out_valid;
  logic [127:0] core_data, core_key, core_out;

  always #5 clk = ~clk;

  aes_core_arbiter #(.TIMEOUT_CYCLES(8), .GAP_CYCLES(3)) dut (
    .AES_clk(clk), .AES_rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .core_en(core_en), .core_data(core_data), .core_key(core_key),
    .core_out(core_out), .core_out_valid(core_out_valid)
  );

  // Behavioural core: result valid on the 11th cycle of core_en.
  logic [3:0] mcnt = 4'd0;
  logic       model_dead = 1'b0;
  always @(posedge clk) mcnt <= core_en ? mcnt + 4'd1 : 4'd0;
  assign core_out_valid = core_en && (mcnt == 4'd10) && !model_dead;
  assign core_out       = core_data ^ core_key;

  typedef struct packed {
    logic         id;
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0, fails = 0;
  int   n_rsp = 0, tot = 0;
  int   low_run = 0, gap_len = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk_d(input int r, input int k);
    return {32'(r), 32'(k), 32'hdead0000 + 32'(k * 7), 32'h01234567 ^ 32'(r * 13)};
  endfunction

  function automatic logic [127:0] mk_k(input int r, input int k);
    return {32'hc0ffee00 ^ 32'(k), 32'(r * 5 + 3), 32'h5a5a5a5a, 32'(k * k + 1)};
  endfunction

  // Response scoreboard and core_en low-run tracker.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      n_rsp++;
      chk("rsp_expected", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 128'(rsp_id), 128'(mon_e.id));
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_err", 128'(rsp_err), 128'(mon_e.err));
      end
    end
    if (core_en === 1'b1) begin
      if (low_run > 0) gap_len = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input int r, input logic [127:0] d, input logic [127:0] k);
    int   g = 0;
    logic seen = 1'b0;
    if (r == 0) begin req0_data = d; req0_key = k; req0_valid = 1'b1; end
    else        begin req1_data = d; req1_key = k; req1_valid = 1'b1; end
    while (!seen && g < 100) begin
      @(negedge clk);
      g++;
      seen = (r == 0) ? req0_ready : req1_ready;
    end
    chk("req_ready_seen", 128'(seen), 128'd1);
    @(posedge clk);
    #1;
    if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic measure_run(input logic [127:0] d, input logic [127:0] k,
                             output int en_cycles, output int hold_bad);
    int g = 0;
    en_cycles = 0;
    hold_bad  = 0;
    while (g < 300) begin
      @(negedge clk);
      g++;
      if (rsp_valid === 1'b1) break;
      if (core_en === 1'b1) begin
        en_cycles++;
        if (core_data !== d || core_key !== k) hold_bad++;
      end
    end
    chk("rsp_valid_rose", 128'(rsp_valid), 128'd1);
  endtask

  task automatic wait_rsp(input int target);
    int g = 0;
    while (n_rsp < target && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("rsp_count", 128'(n_rsp), 128'(target));
  endtask

  // Both requesters hold valid; each accepted item is replaced by the next one.
  task automatic run_both(input int n);
    int k0 = 0, k1 = 0, acc = 0, g = 0;
    req0_data = mk_d(0, 0); req0_key = mk_k(0, 0);
    req1_data = mk_d(1, 0); req1_key = mk_k(1, 0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    while (acc < n && g < 1000) begin
      @(negedge clk);
      g++;
      if (req0_ready === 1'b1) begin
        @(posedge clk); #1;
        k0++; acc++;
        req0_data = mk_d(0, k0); req0_key = mk_k(0, k0);
      end else if (req1_ready === 1'b1) begin
        @(posedge clk); #1;
        k1++; acc++;
        req1_data = mk_d(1, k1); req1_key = mk_k(1, k1);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("both_accepts", 128'(acc), 128'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, k, e;
    int en_c, bad, g, hi;

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", 128'(req0_ready), 128'd0);
    chk("rst_req1_ready", 128'(req1_ready), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_rsp_id", 128'(rsp_id), 128'd0);
    chk("rst_rsp_data", rsp_data, 128'd0);
    chk("rst_rsp_err", 128'(rsp_err), 128'd0);
    chk("rst_core_en", 128'(core_en), 128'd0);
    chk("rst_core_data", core_data, 128'd0);
    chk("rst_core_key", core_key, 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Single request
    d = 128'h000000a7_00000000_00000000_00000000;
    k = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    exp_q.push_back('{id: 1'b0, data: 128'haa2bdbe7_bff6a5e8_caa9ba3e_bc1e2acc, err: 1'b0});
    tot++;
    send(0, d, k);
    measure_run(d, k, en_c, bad);
    chk("single_core_en_cycles", 128'(en_c), 128'd11);
    chk("single_operand_hold", 128'(bad), 128'd0);
    chk("single_core_en_low_in_resp", 128'(core_en), 128'd0);
    wait_rsp(tot);
    repeat (6) @(negedge clk);

    // Simultaneous valids after reset, held for 6 grants: ids alternate from 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back('{id: 1'(i % 2), data: mk_d(i % 2, i / 2) ^ mk_k(i % 2, i / 2), err: 1'b0});
      tot++;
    end
    run_both(6);
    wait_rsp(tot);
    repeat (6) @(negedge clk);

    // Backpressure
    do_reset();
    rsp_ready = 1'b0;
    d = mk_d(0, 40); k = mk_k(0, 40); e = d ^ k;
    exp_q.push_back('{id: 1'b0, data: e, err: 1'b0});
    exp_q.push_back('{id: 1'b1, data: mk_d(1, 41) ^ mk_k(1, 41), err: 1'b0});
    tot += 2;
    send(0, d, k);
    req1_data = mk_d(1, 41); req1_key = mk_k(1, 41); req1_valid = 1'b1;
    g = 0;
    while (rsp_valid !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", 128'(rsp_valid), 128'd1);
      chk("bp_rsp_id", 128'(rsp_id), 128'd0);
      chk("bp_rsp_data", rsp_data, e);
      chk("bp_core_en", 128'(core_en), 128'd0);
      chk("bp_req1_ready", 128'(req1_ready), 128'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    g = 0;
    while (req1_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
    chk("bp_req1_later_granted", 128'(req1_ready), 128'd1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_rsp(tot);
    repeat (6) @(negedge clk);

    // Gap between operations with same-cycle rsp_ready
    do_reset();
    exp_q.push_back('{id: 1'b0, data: mk_d(0, 0) ^ mk_k(0, 0), err: 1'b0});
    exp_q.push_back('{id: 1'b1, data: mk_d(1, 0) ^ mk_k(1, 0), err: 1'b0});
    tot += 2;
    run_both(2);
    repeat (2) @(negedge clk);
    chk("gap_low_cycles", 128'(gap_len), 128'd5);
    wait_rsp(tot);
    repeat (6) @(negedge clk);

    // Reset during RUN discards the operation
    do_reset();
    send(0, mk_d(0, 77), mk_k(0, 77));
    repeat (4) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_run_core_en_before_rst", 128'(core_en), 128'd1);
    @(negedge clk);
    chk("mid_run_core_en_after_rst", 128'(core_en), 128'd0);
    chk("mid_run_rsp_valid_after_rst", 128'(rsp_valid), 128'd0);
    chk("mid_run_core_data_after_rst", core_data, 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    hi = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid !== 1'b0) hi++; end
    chk("mid_run_no_response", 128'(hi), 128'd0);
    exp_q.push_back('{id: 1'b1, data: mk_d(1, 9) ^ mk_k(1, 9), err: 1'b0});
    tot++;
    send(1, mk_d(1, 9), mk_k(1, 9));
    wait_rsp(tot);
    repeat (6) @(negedge clk);

`ifdef AES_ARB_TIMEOUT_EN
    // Timeout with a core that never answers
    do_reset();
    model_dead = 1'b1;
    d = mk_d(0, 5); k = mk_k(0, 5);
    exp_q.push_back('{id: 1'b0, data: 128'd0, err: 1'b1});
    tot++;
    send(0, d, k);
    measure_run(d, k, en_c, bad);
    chk("timeout_core_en_cycles", 128'(en_c), 128'd9);
    chk("timeout_rsp_err", 128'(rsp_err), 128'd1);
    wait_rsp(tot);
    model_dead = 1'b0;
    repeat (6) @(negedge clk);
`endif

    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
